i2c_master_arbiter: RTL

- Shares the single I2C master core between two requesting FSMs, e.g. two sensor read-out FSMs on one bus.
- Grants the core to one requester at a time using round-robin and holds the grant for the whole transaction, including the FIFO read-out.
- Muxes the owner's I2C control/data signals to the core; the non-owner sees a busy core.
- Sits between the requester FSMs and the I2C core ports (StartProcess/Busy/FIFO/Data/Error).

---
 rtl/i2c_arb_pkg.sv | 18 +
 rtl/i2c_arb_mux.sv | 59 +++++
 rtl/i2c_master_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-requester I2C master arbiter.
//   state_t : arbiter FSM states
//   NumReq  : number of requesters sharing the core
//   ByteW   : width of one I2C data / read-count byte
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANTED,
        RUNNING,
        HELD,
        RELEASE
    } state_t;

    localparam int NumReq = 2;
    localparam int ByteW  = 8;

endpackage

// File: rtl/i2c_arb_mux.sv
// Owner-select mux between the requesters and the single I2C master core.
// Purely combinational.
//   gnt               : one-hot-or-zero grant from the arbiter FSM
//   receive_send_n .. data : per-requester control/data toward the core
//   core_busy/error   : status coming back from the core
//   core_*            : selected owner's signals to the core, 0 with no owner
//   busy/error        : per-requester status views; a non-owner sees a busy,
//                       error-free core
module i2c_arb_mux
    import i2c_arb_pkg::*;
(
    input  logic [NumReq-1:0]       gnt,
    input  logic [NumReq-1:0]       receive_send_n,
    input  logic [NumReq*ByteW-1:0] read_count,
    input  logic [NumReq-1:0]       start_process,
    input  logic [NumReq-1:0]       fifo_read_next,
    input  logic [NumReq-1:0]       fifo_write,
    input  logic [NumReq*ByteW-1:0] data,
    input  logic                    core_busy,
    input  logic                    core_error,
    output logic                    core_receive_send_n,
    output logic [ByteW-1:0]        core_read_count,
    output logic                    core_start_process,
    output logic                    core_fifo_read_next,
    output logic                    core_fifo_write,
    output logic [ByteW-1:0]        core_data,
    output logic [NumReq-1:0]       busy,
    output logic [NumReq-1:0]       error
);

    logic owned;
    logic owner;

    // Grant is one-hot, so bit 1 doubles as the owner index.
    assign owned = |gnt;
    assign owner = gnt[1];

    always_comb begin
        core_receive_send_n = 1'b0;
        core_read_count     = '0;
        core_start_process  = 1'b0;
        core_fifo_read_next = 1'b0;
        core_fifo_write     = 1'b0;
        core_data           = '0;
        busy                = '1;
        error               = '0;
        if (owned) begin
            core_receive_send_n = receive_send_n[owner];
            core_read_count     = read_count[ByteW*int'(owner) +: ByteW];
            core_start_process  = start_process[owner];
            core_fifo_read_next = fifo_read_next[owner];
            core_fifo_write     = fifo_write[owner];
            core_data           = data[ByteW*int'(owner) +: ByteW];
            busy[owner]         = core_busy;
            error[owner]        = core_error;
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master core between two requester FSMs.
// The grant is held for a whole transaction including FIFO read-out; a grant
// that never sees StartProcess is revoked after StartTimeout cycles.
//   Clk_i, Reset_i          : clock, asynchronous active-high reset
//   Req_i / Gnt_o           : per-requester request, registered one-hot grant
//   ReceiveSend_n_i .. Data_i : per-requester core controls, [8k+7:8k] bytes
//   Busy_o, Error_o         : per-requester view of the core status
//   Data_o                  : core read byte, broadcast
//   I2C_*                   : core-side ports
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int StartTimeout = 255
)
(
    input  logic                    Clk_i,
    input  logic                    Reset_i,
    input  logic [NumReq-1:0]       Req_i,
    output logic [NumReq-1:0]       Gnt_o,
    input  logic [NumReq-1:0]       ReceiveSend_n_i,
    input  logic [NumReq*ByteW-1:0] ReadCount_i,
    input  logic [NumReq-1:0]       StartProcess_i,
    input  logic [NumReq-1:0]       FIFOReadNext_i,
    input  logic [NumReq-1:0]       FIFOWrite_i,
    input  logic [NumReq*ByteW-1:0] Data_i,
    output logic [NumReq-1:0]       Busy_o,
    output logic [NumReq-1:0]       Error_o,
    output logic [ByteW-1:0]        Data_o,
    output logic                    I2C_ReceiveSend_n_o,
    output logic [ByteW-1:0]        I2C_ReadCount_o,
    output logic                    I2C_StartProcess_o,
    output logic                    I2C_FIFOReadNext_o,
    output logic                    I2C_FIFOWrite_o,
    output logic [ByteW-1:0]        I2C_Data_o,
    input  logic                    I2C_Busy_i,
    input  logic                    I2C_Error_i,
    input  logic [ByteW-1:0]        I2C_Data_i
);

    localparam logic [15:0] TimeoutLoad = 16'(StartTimeout);

    state_t            state, state_nxt;
    logic [NumReq-1:0] gnt_nxt;
    logic              last_gnt, last_gnt_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic              busy_q;
    logic              winner;
    logic              owner_req;

    // With both requesting, the one not served last wins.
    assign winner    = (&Req_i) ? ~last_gnt : Req_i[1];
    assign owner_req = Req_i[Gnt_o[1]];
    assign Data_o    = I2C_Data_i;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state    <= IDLE;
            Gnt_o    <= '0;
            last_gnt <= 1'b1;
            cnt      <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            Gnt_o    <= gnt_nxt;
            last_gnt <= last_gnt_nxt;
            cnt      <= cnt_nxt;
            busy_q   <= I2C_Busy_i;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = Gnt_o;
        last_gnt_nxt = last_gnt;
        cnt_nxt      = cnt;
        case (state)
            IDLE: begin
                if (|Req_i) begin
                    state_nxt    = GRANTED;
                    gnt_nxt      = winner ? 2'b10 : 2'b01;
                    last_gnt_nxt = winner;
                    cnt_nxt      = TimeoutLoad;
                end
            end
            GRANTED: begin
                cnt_nxt = cnt - 16'd1;
                if (I2C_Busy_i) begin
                    state_nxt = RUNNING;
                end else if (!owner_req) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = '0;
                end else if (cnt <= 16'd1) begin
                    // A start issued on the expiring cycle already reached the
                    // core, so wait for its transaction rather than revoking.
                    if (I2C_StartProcess_o) begin
                        state_nxt = RUNNING;
                    end else begin
                        state_nxt = RELEASE;
                        gnt_nxt   = '0;
                    end
                end
            end
            RUNNING: begin
                // Falling edge of Busy; a late start enters here with Busy
                // still low and must see it rise first.
                if (busy_q && !I2C_Busy_i) begin
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (I2C_Busy_i) begin
                    state_nxt = RUNNING;
                end else if (!owner_req) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = '0;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    i2c_arb_mux u_mux (
        .gnt                 (Gnt_o),
        .receive_send_n      (ReceiveSend_n_i),
        .read_count          (ReadCount_i),
        .start_process       (StartProcess_i),
        .fifo_read_next      (FIFOReadNext_i),
        .fifo_write          (FIFOWrite_i),
        .data                (Data_i),
        .core_busy           (I2C_Busy_i),
        .core_error          (I2C_Error_i),
        .core_receive_send_n (I2C_ReceiveSend_n_o),
        .core_read_count     (I2C_ReadCount_o),
        .core_start_process  (I2C_StartProcess_o),
        .core_fifo_read_next (I2C_FIFOReadNext_o),
        .core_fifo_write     (I2C_FIFOWrite_o),
        .core_data           (I2C_Data_o),
        .busy                (Busy_o),
        .error               (Error_o)
    );

endmodule
